if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle control decoder. Owns the PC and fetches one 32-bit instruction per step from instruction memory over a req/ack handshake.
- Presents the instruction to the decoder with valid/ready.
- Computes next-PC from decoder/datapath redirect inputs: jump select, and branch-taken (beq & zero).
- Watchdog flags an instruction-memory response that never arrives.

---
 rtl/if_fetch_unit_pkg.sv | 32 +++
 rtl/if_fetch_unit_if.sv | 34 +++
 rtl/if_fetch_unit_next_pc.sv | 28 ++
 rtl/if_fetch_unit.sv | 100 ++++++++++
 tb/tb_if_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   - FS_* : fetch FSM state encoding (REQ waits on memory, ISSUE holds an
//            instruction for the decoder, ERR is the sticky watchdog state)
//   - INST_W : instruction width
//   - OP_* / FN_* : opcode and function codes shared with the control decoder
//   - branch_offset() : word-scaled, sign-extended 16-bit branch displacement
package if_fetch_unit_pkg;

    localparam int INST_W = 32;

    localparam logic [1:0] FS_REQ   = 2'd0;
    localparam logic [1:0] FS_ISSUE = 2'd1;
    localparam logic [1:0] FS_ERR   = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of everything the fetch unit exchanges with instruction memory and
// with the decoder/datapath.
//   master : the fetch unit (drives im_req/im_addr, inst/inst_valid, pc,
//            pc_plus4, im_fault; receives memory data and redirect inputs)
//   slave  : the environment (memory + decoder/datapath)
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic              im_req;
    logic [31:0]       im_addr;
    logic [INST_W-1:0] im_rdata;
    logic              im_ack;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              jump;
    logic              branch_taken;
    logic [15:0]       imm16;
    logic [25:0]       target26;
    logic              im_fault;

    modport master (
        output im_req, im_addr, inst, inst_valid, pc, pc_plus4, im_fault,
        input  im_rdata, im_ack, inst_ready, jump, branch_taken, imm16, target26
    );

    modport slave (
        input  im_req, im_addr, inst, inst_valid, pc, pc_plus4, im_fault,
        output im_rdata, im_ack, inst_ready, jump, branch_taken, imm16, target26
    );

endinterface

// File: rtl/if_fetch_unit_next_pc.sv
// Combinational next-PC selection for the fetch unit.
//   pc, jump, branch_taken, imm16, target26 -> pc_plus4, next_pc
// Jump has priority over a taken branch; all arithmetic wraps modulo 2^32.
module if_fetch_unit_next_pc
    import if_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    // Sequential, jump and branch targets with jump taking priority
    always_comb begin
        pc_plus4 = pc + 32'd4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], target26, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset(imm16);
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one instruction per step over
// a req/ack handshake and hands it to the decoder with valid/ready.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : if_fetch_unit_if.master (memory req/ack, decoder valid/ready,
//              pc/pc_plus4, redirect inputs, sticky im_fault)
// A watchdog moves to a terminal ERR state if memory never acks; only rst
// leaves ERR. Redirect inputs are only looked at on the retire cycle.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IM_TIMEOUT = 16,
    parameter int          CNT_W      = 5
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(IM_TIMEOUT - 1);

    logic [1:0]        state_r;
    logic [31:0]       pc_r;
    logic [INST_W-1:0] inst_r;
    logic              inst_valid_r;
    logic              im_req_r;
    logic              im_fault_r;
    logic [CNT_W-1:0]  wd_cnt_r;
    logic [31:0]       pc_plus4_s;
    logic [31:0]       next_pc_s;

    if_fetch_unit_next_pc u_next_pc (
        .pc           (pc_r),
        .jump         (bus.jump),
        .branch_taken (bus.branch_taken),
        .imm16        (bus.imm16),
        .target26     (bus.target26),
        .pc_plus4     (pc_plus4_s),
        .next_pc      (next_pc_s)
    );

    // Fetch FSM, watchdog counter and the instruction/PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FS_REQ;
            pc_r         <= RESET_PC;
            inst_r       <= {INST_W{1'b0}};
            inst_valid_r <= 1'b0;
            im_req_r     <= 1'b1;
            im_fault_r   <= 1'b0;
            wd_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                FS_REQ: begin
                    if (bus.im_ack) begin
                        inst_r       <= bus.im_rdata;
                        inst_valid_r <= 1'b1;
                        im_req_r     <= 1'b0;
                        wd_cnt_r     <= {CNT_W{1'b0}};
                        state_r      <= FS_ISSUE;
                    end else if (wd_cnt_r == WD_LAST) begin
                        // Last allowed cycle passed without a response
                        im_fault_r <= 1'b1;
                        im_req_r   <= 1'b0;
                        state_r    <= FS_ERR;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                FS_ISSUE: begin
                    if (bus.inst_ready) begin
                        pc_r         <= next_pc_s;
                        inst_valid_r <= 1'b0;
                        im_req_r     <= 1'b1;
                        state_r      <= FS_REQ;
                    end
                end
                FS_ERR: begin
                    im_fault_r <= 1'b1;
                end
                default: begin
                    // Corrupted state register: park safely in ERR
                    state_r      <= FS_ERR;
                    inst_valid_r <= 1'b0;
                    im_req_r     <= 1'b0;
                    im_fault_r   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.im_req     = im_req_r;
    assign bus.im_addr    = pc_r;
    assign bus.inst       = inst_r;
    assign bus.inst_valid = inst_valid_r;
    assign bus.pc         = pc_r;
    assign bus.pc_plus4   = pc_plus4_s;
    assign bus.im_fault   = im_fault_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a driver plays memory and decoder,
// pushing the expected {inst, pc} of every acked fetch; a separate monitor
// pops and compares whenever a new instruction is presented.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IM_TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    typedef struct packed {
        logic        jump;
        logic        br;
        logic [15:0] imm16;
        logic [25:0] target26;
    } redir_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IM_TIMEOUT (IM_TIMEOUT),
        .CNT_W      (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    redir_t      dir_q[$];
    logic [31:0] rdata_q[$];
    logic [31:0] model_pc = RESET_PC;
    int          lat_max = 0, lat_target = 0, lat_cnt = 0, hold_cnt = 0;
    bit          rand_ready = 1'b0, no_ack = 1'b0, perf_mode = 1'b0, noise = 1'b1;
    int          fault_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Reference next-PC, straight from the architectural rules
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input redir_t r);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        if (r.jump) return (seq & 32'hF000_0000) | (32'(r.target26) * 32'd4);
        if (r.br) begin
            off = int'($signed(r.imm16)) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    function automatic redir_t rand_redir();
        redir_t r;
        r.jump     = ($urandom_range(3, 0) == 0);
        r.br       = ($urandom_range(2, 0) == 0);
        r.imm16    = 16'($urandom);
        r.target26 = 26'($urandom);
        return r;
    endfunction

    task automatic push_dir(input logic j, input logic b, input logic [15:0] imm, input logic [25:0] t);
        redir_t r;
        r.jump = j; r.br = b; r.imm16 = imm; r.target26 = t;
        dir_q.push_back(r);
    endtask

    // One cycle of memory + decoder behaviour, driven on the falling edge
    task automatic drive_cycle();
        redir_t r;
        exp_t   e;
        @(negedge clk);
        if (bus.im_req && !no_ack && lat_cnt >= lat_target) begin
            bus.im_ack = 1'b1;
            if (rdata_q.size() > 0) bus.im_rdata = rdata_q.pop_front();
            else bus.im_rdata = $urandom;
            e.inst = bus.im_rdata;
            e.pc   = model_pc;
            exp_q.push_back(e);
            lat_cnt    = 0;
            lat_target = $urandom_range(lat_max, 0);
        end else if (bus.im_req) begin
            bus.im_ack = 1'b0;
            lat_cnt++;
        end else begin
            bus.im_ack   = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            bus.im_rdata = $urandom;
        end
        if (bus.inst_valid) begin
            r = (dir_q.size() > 0) ? dir_q[0] : rand_redir();
            if (hold_cnt > 0) begin
                bus.inst_ready = 1'b0;
                hold_cnt--;
            end else begin
                bus.inst_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            end
            if (bus.inst_ready) begin
                if (dir_q.size() > 0) void'(dir_q.pop_front());
                model_pc = ref_next(model_pc, r);
            end
        end else begin
            r = rand_redir();
            bus.inst_ready = 1'($urandom_range(1, 0));
        end
        bus.jump         = r.jump;
        bus.branch_taken = r.br;
        bus.imm16        = r.imm16;
        bus.target26     = r.target26;
    endtask

    task automatic wait_valid(input string name);
        for (int c = 0; c < 50; c++) begin
            drive_cycle();
            if (bus.inst_valid) break;
        end
        check(name, 32'(bus.inst_valid), 32'd1);
    endtask

    task automatic do_reset(input bit with_redirect);
        @(negedge clk);
        rst              = 1'b1;
        bus.im_ack       = 1'b0;
        bus.inst_ready   = with_redirect;
        bus.jump         = with_redirect;
        bus.branch_taken = with_redirect;
        bus.imm16        = 16'h0010;
        bus.target26     = 26'h000_0040;
        exp_q.delete();
        model_pc   = RESET_PC;
        lat_cnt    = 0;
        lat_target = 0;
        @(posedge clk);
        #2;
        check("rst_pc", bus.pc, RESET_PC);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_im_fault", 32'(bus.im_fault), 32'd0);
        check("rst_im_req", 32'(bus.im_req), 32'd1);
        rst = 1'b0;
    endtask

    // Monitor: compares every presented instruction against the scoreboard
    initial begin : monitor
        logic prev_valid;
        exp_t cur;
        bit   have_cur;
        prev_valid = 1'b0;
        have_cur   = 1'b0;
        cur        = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_valid = 1'b0;
                have_cur   = 1'b0;
            end else begin
                if (bus.inst_valid && !prev_valid) begin
                    check("pending_fetches", 32'(exp_q.size()), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (bus.inst_valid && have_cur) begin
                    check("inst", bus.inst, cur.inst);
                    check("pc", bus.pc, cur.pc);
                    check("im_addr", bus.im_addr, cur.pc);
                    check("pc_plus4", bus.pc_plus4, cur.pc + 32'd4);
                    check("im_req_in_issue", 32'(bus.im_req), 32'd0);
                end
                if (!bus.inst_valid) have_cur = 1'b0;
                if (perf_mode) check("valid_toggle", 32'(bus.inst_valid), 32'(!prev_valid));
                prev_valid = bus.inst_valid;
            end
        end
    end

    initial begin
        bus.im_ack = 1'b0; bus.im_rdata = 32'd0; bus.inst_ready = 1'b0;
        bus.jump = 1'b0; bus.branch_taken = 1'b0; bus.imm16 = 16'd0; bus.target26 = 26'd0;
        do_reset(1'b0);

        // Zero-wait directed walk through sequential, branch, wrap and jump cases
        rdata_q.push_back(32'h2002_0005);
        push_dir(1'b0, 1'b0, 16'h0000, 26'h0);          // 0 -> 4
        push_dir(1'b0, 1'b0, 16'h0000, 26'h0);          // 4 -> 8
        push_dir(1'b0, 1'b1, 16'hFFFC, 26'h0);          // 8 -> FFFF_FFFC
        push_dir(1'b0, 1'b0, 16'h0000, 26'h0);          // FFFF_FFFC -> 0
        push_dir(1'b1, 1'b0, 16'h0000, 26'h4);          // 0 -> 10
        push_dir(1'b0, 1'b1, 16'hFFFC, 26'h0);          // 10 -> 4
        push_dir(1'b1, 1'b0, 16'h0000, 26'h4);          // 4 -> 10
        push_dir(1'b0, 1'b1, 16'h0003, 26'h0);          // 10 -> 20
        push_dir(1'b1, 1'b0, 16'h0000, 26'h3FF_FFFF);   // 20 -> 0FFF_FFFC
        push_dir(1'b0, 1'b0, 16'h0000, 26'h0);          // -> 1000_0000
        push_dir(1'b0, 1'b0, 16'h0000, 26'h0);          // -> 1000_0004
        push_dir(1'b0, 1'b0, 16'h0000, 26'h0);          // -> 1000_0008
        push_dir(1'b1, 1'b1, 16'h1234, 26'h040);        // jump wins -> 1000_0100
        perf_mode = 1'b1;
        for (int c = 0; c < 100 && dir_q.size() > 0; c++) drive_cycle();
        perf_mode = 1'b0;
        check("directed_drained", 32'(dir_q.size()), 32'd0);

        // Hold the decoder off for 5 cycles, then a plain retire
        push_dir(1'b0, 1'b0, 16'h0000, 26'h0);
        hold_cnt = 5;
        wait_valid("wait_jump_target");
        check("jump_wins_pc", bus.pc, 32'h1000_0100);
        repeat (4) drive_cycle();
        check("held_valid", 32'(bus.inst_valid), 32'd1);
        check("held_im_req", 32'(bus.im_req), 32'd0);
        check("held_pc", bus.pc, 32'h1000_0100);
        wait_valid("wait_release");
        wait_valid("wait_after_hold");
        check("after_hold_pc", bus.pc, 32'h1000_0104);

        // Random latency, random ready, random redirects
        lat_max    = 3;
        rand_ready = 1'b1;
        repeat (600) drive_cycle();

        // Watchdog: retire, then memory goes silent
        lat_max    = 0;
        rand_ready = 1'b0;
        hold_cnt   = 0;
        wait_valid("wait_before_timeout");
        no_ack    = 1'b1;
        fault_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            drive_cycle();
            if (bus.im_fault) begin
                fault_cyc = c;
                break;
            end
        end
        check("timeout_cycles", 32'(fault_cyc), 32'(IM_TIMEOUT));
        repeat (6) drive_cycle();
        check("err_fault_sticky", 32'(bus.im_fault), 32'd1);
        check("err_im_req", 32'(bus.im_req), 32'd0);
        check("err_inst_valid", 32'(bus.inst_valid), 32'd0);
        no_ack = 1'b0;
        do_reset(1'b0);

        // Reset while an instruction is retiring with a jump pending
        hold_cnt = 100;
        wait_valid("wait_before_rst_issue");
        do_reset(1'b1);
        hold_cnt = 0;
        lat_max    = 2;
        rand_ready = 1'b1;
        repeat (40) drive_cycle();

        @(posedge clk);
        #2;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
